// File: rtl/tdc_readout_pkg.sv
// Shared types and constants for the FIFO readout path (state encoding, word/byte geometry).
package tdc_readout_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        HDR,
        SEND
    } state_e;

    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        idx);
        return word[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/fifo_readout_ctrl_byte_serializer.sv
// Holds one popped word and emits it MSB byte first on a valid/ready stream.
// FRAME_HEADER_EN prefixes each word with SYNC_BYTE.
module byte_serializer
    import tdc_readout_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              tx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              done
);

    logic [WORD_W-1:0] hold;
    logic [1:0]        idx;
    logic              xfer;

    assign xfer = tx_valid & tx_ready;

`ifdef FRAME_HEADER_EN
    logic hdr_pending;

    assign done = xfer & ~hdr_pending & (idx == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold        <= '0;
            idx         <= 2'd0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            hdr_pending <= 1'b0;
        end else if (load) begin
            hold        <= load_data;
            idx         <= 2'd3;
            tx_valid    <= 1'b1;
            tx_data     <= SYNC_BYTE;
            hdr_pending <= 1'b1;
        end else if (xfer) begin
            if (hdr_pending) begin
                hdr_pending <= 1'b0;
                tx_data     <= word_byte(hold, idx);
            end else if (idx != 2'd0) begin
                idx     <= idx - 2'd1;
                tx_data <= word_byte(hold, idx - 2'd1);
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_sync;

    assign unused_sync = ^SYNC_BYTE;
    assign done        = xfer & (idx == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            idx      <= 2'd0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (load) begin
            hold     <= load_data;
            idx      <= 2'd3;
            tx_valid <= 1'b1;
            tx_data  <= word_byte(load_data, 2'd3);
        end else if (xfer) begin
            // tx_data only advances on a completed handshake, so it is stable across stalls
            if (idx != 2'd0) begin
                idx     <= idx - 2'd1;
                tx_data <= word_byte(hold, idx - 2'd1);
            end else begin
                tx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/fifo_readout_ctrl.sv
// Read-side controller for the merging FIFO: pops one word at a time, waits out the FIFO read
// latency and hands the word to the byte serializer. Optional macro: FRAME_HEADER_EN.
module fifo_readout_ctrl
    import tdc_readout_pkg::*;
#(
    parameter int                READ_LATENCY = 2,
    parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic              Rclk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_rden,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       word_count
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_e     state;
    state_e     state_next;
    logic [1:0] lat_cnt;
    logic       lat_done;
    logic       load;
    logic       done;
    logic       rden_next;
    logic       busy_next;

    assign lat_done = (lat_cnt == LAT_LAST);

    always_ff @(posedge Rclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!fifo_empty) state_next = RD;
            RD:   state_next = WAIT;
            WAIT: begin
                if (lat_done) begin
`ifdef FRAME_HEADER_EN
                    state_next = HDR;
`else
                    state_next = SEND;
`endif
                end
            end
`ifdef FRAME_HEADER_EN
            HDR:  if (tx_ready) state_next = SEND;
`endif
            SEND: if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, keeping inputs off output paths.
    always_comb begin
        load      = (state == WAIT) && lat_done;
        rden_next = (state_next == RD);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge Rclk) begin
        if (rst) begin
            fifo_rden  <= 1'b0;
            busy       <= 1'b0;
            lat_cnt    <= 2'd0;
            word_count <= 16'h0000;
        end else begin
            fifo_rden <= rden_next;
            busy      <= busy_next;
            if (state == RD) begin
                lat_cnt <= 2'd0;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            if (done) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

    byte_serializer #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_serializer (
        .clk       (Rclk),
        .rst       (rst),
        .load      (load),
        .load_data (fifo_data),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (done)
    );

endmodule

// File: tb/tb_fifo_readout_ctrl.sv
// Bench for fifo_readout_ctrl: queue-based FIFO and byte-stream model, directed and random traffic.
module tb_fifo_readout_ctrl;

    localparam int RL = 2;
`ifdef FRAME_HEADER_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_rden;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    fifo_readout_ctrl #(
        .READ_LATENCY (RL),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .Rclk       (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rden  (fifo_rden),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .word_count (word_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle time %0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int          cyc = 0;
    int          data_due = -1;
    logic [31:0] data_word = 32'h0;
    logic        expect_rden = 1'b0;
    int          valid_due = -1;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [7:0]  prev_d = 8'h0;
    int          nbytes = 0;
    logic [15:0] model_count = 16'h0;
    logic        rst_q = 1'b1;
    int          rden_cnt = 0;
    int          byte_cnt = 0;
    int          last_rden_cyc = 0;
    int          last_hs_cyc = 0;
    bit          rand_ready = 1'b0;

    task automatic monitor();
        cyc++;
        if (rst_q) begin
            check_eq("reset_outs", {5'd0, fifo_rden, tx_valid, busy, tx_data, word_count}, 32'd0);
        end else begin
            check_eq("rden", fifo_rden, expect_rden);
            if (fifo_rden) check_eq("rden_after_last_byte", exp_q.size(), 0);
            if (cyc == valid_due - 1) check_eq("valid_early", tx_valid, 1'b0);
            if (cyc == valid_due) check_eq("first_valid", tx_valid, 1'b1);
            if (prev_v && !prev_r) check_eq("stall_hold", {tx_valid, tx_data}, {1'b1, prev_d});
            if (tx_valid || fifo_rden) check_eq("busy", busy, 1'b1);
            check_eq("word_count", word_count, model_count);
        end

        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            nbytes      = 0;
            model_count = 16'h0;
            expect_rden = 1'b0;
            valid_due   = -1;
            data_due    = -1;
            prev_v      = 1'b0;
            rden_cnt    = 0;
            byte_cnt    = 0;
            fifo_data   = 32'h0;
        end else begin
            if (tx_valid && tx_ready) begin
                check_eq("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check_eq("tx_data", tx_data, exp_q.pop_front());
                byte_cnt++;
                last_hs_cyc = cyc;
                nbytes++;
                if (nbytes == NB) begin
                    nbytes = 0;
                    model_count++;
                end
            end
            if (fifo_rden && fifo_q.size() != 0) begin
                data_word = fifo_q.pop_front();
                data_due  = cyc + RL;
                valid_due = cyc + RL + 1;
                rden_cnt++;
                last_rden_cyc = cyc;
`ifdef FRAME_HEADER_EN
                exp_q.push_back(8'hA5);
`endif
                for (int i = 3; i >= 0; i--) exp_q.push_back(8'(data_word >> (8 * i)));
            end
            // the popped word becomes visible exactly RL cycles after the read pulse
            if (cyc == data_due) fifo_data = data_word;
            expect_rden = !busy && (fifo_q.size() != 0);
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
        end
        fifo_empty = (fifo_q.size() == 0);
        rst_q = rst;
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(fifo_q.size() == 0 && !busy && !fifo_rden && exp_q.size() == 0) && n < max_cyc);
        check_eq("drain_in_time", n < max_cyc, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(posedge clk);
        #1;

        // single word, ready tied high
        reset_dut();
        tx_ready = 1'b1;
        push(32'h12345678);
        wait_idle(100);
        check_eq("t1_rden_pulses", rden_cnt, 1);
        check_eq("t1_bytes", byte_cnt, NB);
        check_eq("t1_count", word_count, 16'd1);
        check_eq("t1_busy", busy, 1'b0);
        check_eq("t1_word_cycle", last_hs_cyc - last_rden_cyc, RL + NB);

        // three queued words
        reset_dut();
        tx_ready = 1'b1;
        push(32'h12345678);
        push(32'h9ABCDEF0);
        push(32'h0F1E2D3C);
        wait_idle(200);
        check_eq("t2_rden_pulses", rden_cnt, 3);
        check_eq("t2_bytes", byte_cnt, 3 * NB);
        check_eq("t2_count", word_count, 16'd3);

        // ready pattern 1-0-0-1 once the first byte is offered
        reset_dut();
        tx_ready = 1'b1;
        push(32'hA1B2C3D4);
        push(32'h55AA33CC);
        n = 0;
        while (!tx_valid && n < 20) begin
            cycle();
            n++;
        end
        check_eq("t3_valid_seen", tx_valid, 1'b1);
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        cycle();
        cycle();
        tx_ready = 1'b1;
        wait_idle(200);
        check_eq("t3_bytes", byte_cnt, 2 * NB);
        check_eq("t3_count", word_count, 16'd2);

        // reset while waiting on FIFO latency
        reset_dut();
        tx_ready = 1'b1;
        push(32'hCAFEF00D);
        n = 0;
        while (rden_cnt == 0 && n < 20) begin
            cycle();
            n++;
        end
        check_eq("t4_rden_seen", rden_cnt, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        push(32'hDEADBEEF);
        wait_idle(100);
        check_eq("t4_bytes", byte_cnt, NB);
        check_eq("t4_count", word_count, 16'd1);

        // word_count wrap
        reset_dut();
        tx_ready = 1'b1;
        force dut.word_count = 16'hFFFF;
        model_count = 16'hFFFF;
        cycle();
        release dut.word_count;
        cycle();
        push(32'h0BADCAFE);
        wait_idle(100);
        check_eq("t5_wrap", word_count, 16'h0000);

        // empty FIFO for 100 cycles
        reset_dut();
        for (int i = 0; i < 100; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            cycle();
            check_eq("t6_idle", {fifo_rden, tx_valid, busy}, 3'b000);
        end

        // random traffic with random backpressure and occasional reset
        reset_dut();
        rand_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) push($urandom);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        wait_idle(3000);
        check_eq("rand_count", word_count, model_count);
        check_eq("rand_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
